disp_scan_ctrl: RTL and testbench

Four-digit time-multiplexed scan controller that drives the shared hex-to-7-segment decoder stage directly downstream: one nibble (D3..D0), one LE and one POINT per active digit, plus the active-low common-anode select lines.
- Holds a double-buffered 16-bit display value with per-digit enable and point masks.
- Inserts an anti-ghosting blank window at the start of every digit slot.
- Optional leading-zero suppression.
- Sits between CPU/debug display sources and the decoder on the board display path.

---
 rtl/disp_scan_ctrl_pkg.sv | 19 +
 rtl/disp_scan_ctrl_if.sv | 24 ++
 rtl/disp_slot_timer.sv | 58 +++++
 rtl/disp_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the four-digit multiplexed display path.
package disp_scan_ctrl_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam logic [3:0]  AN_OFF = 4'b1111;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b0001 << idx;
    return ~sel;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host-side load bus plus decoder/anode drive lines of the scan controller.
interface disp_scan_ctrl_if;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        lzs;
  logic        load;
  logic        busy;
  logic [3:0]  AN;
  logic [3:0]  D;
  logic        LE;
  logic        POINT;
  logic [1:0]  digit;

  modport master (
    output hexs, points, les, lzs, load,
    input  busy, AN, D, LE, POINT, digit
  );

  modport slave (
    input  hexs, points, les, lzs, load,
    output busy, AN, D, LE, POINT, digit
  );
endinterface

// File: rtl/disp_slot_timer.sv
// Slot counter, digit index and BLANK/DRIVE phase of each digit slot.
module disp_slot_timer
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] DIV       = 16'd50000,
  parameter logic [CNT_W-1:0] BLANK_CYC = 16'd500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] digit_o,
  output logic       blank_o,
  output logic       frame_start_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  phase_e           phase_q, phase_d;
  logic             wrap_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      digit_q <= 2'd0;
      phase_q <= PH_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    wrap_s = (cnt_q == LAST);
    if (wrap_s) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      digit_d = digit_q;
    end
    if (cnt_d < BLANK_CYC) begin
      phase_d = PH_BLANK;
    end else begin
      phase_d = PH_DRIVE;
    end
  end

  // frame_start fires in the last cycle of digit 3, so the buffer swap lands on the wrap edge
  always_comb begin
    blank_o       = (phase_q == PH_BLANK);
    digit_o       = digit_q;
    frame_start_o = wrap_s && (digit_q == 2'd3);
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit scan controller: double-buffered value, blank window, leading-zero suppression.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] DIV       = 16'd50000,
  parameter logic [CNT_W-1:0] BLANK_CYC = 16'd500
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  logic [1:0] digit_s;
  logic       blank_s;
  logic       frame_start_s;

  disp_slot_timer #(
    .CNT_W     (CNT_W),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk_i         (clk),
    .rst_i         (rst),
    .digit_o       (digit_s),
    .blank_o       (blank_s),
    .frame_start_o (frame_start_s)
  );

  logic [DIGITS*NIB_W-1:0] pend_hex_q, pend_hex_d, act_hex_q, act_hex_d;
  logic [DIGITS-1:0]       pend_pts_q, pend_pts_d, act_pts_q, act_pts_d;
  logic [DIGITS-1:0]       pend_les_q, pend_les_d, act_les_q, act_les_d;
  logic                    busy_q, busy_d;
  logic [3:0]              an_q, an_d;
  logic [NIB_W-1:0]        d_q, d_d;
  logic                    le_q, le_d, pt_q, pt_d;
  logic [DIGITS-1:0]       zero_up_s;
  logic                    suppressed_s;

  // Frame swap is applied before a same-cycle load, so that load stays pending
  always_comb begin
    pend_hex_d = pend_hex_q;
    pend_pts_d = pend_pts_q;
    pend_les_d = pend_les_q;
    act_hex_d  = act_hex_q;
    act_pts_d  = act_pts_q;
    act_les_d  = act_les_q;
    busy_d     = busy_q;
    if (frame_start_s && busy_q) begin
      act_hex_d = pend_hex_q;
      act_pts_d = pend_pts_q;
      act_les_d = pend_les_q;
      busy_d    = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (bus.load) begin
      pend_hex_d = bus.hexs;
      pend_pts_d = bus.points;
      pend_les_d = bus.les;
      busy_d     = 1'b1;
    end else begin
      pend_hex_d = pend_hex_d;
    end
  end

  always_comb begin
    zero_up_s    = '0;
    zero_up_s[3] = (act_hex_q[15:12] == 4'h0);
    zero_up_s[2] = zero_up_s[3] && (act_hex_q[11:8] == 4'h0);
    zero_up_s[1] = zero_up_s[2] && (act_hex_q[7:4] == 4'h0);
    zero_up_s[0] = zero_up_s[1] && (act_hex_q[3:0] == 4'h0);
    suppressed_s = bus.lzs && (digit_s != 2'd0) && zero_up_s[digit_s];
    d_d          = act_hex_q[digit_s*NIB_W +: NIB_W];
    if (blank_s) begin
      an_d = AN_OFF;
      le_d = 1'b0;
      pt_d = 1'b0;
    end else begin
      an_d = an_onehot_low(digit_s);
      le_d = act_les_q[digit_s] && !suppressed_s;
      pt_d = act_pts_q[digit_s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_hex_q <= '0;
      pend_pts_q <= '0;
      pend_les_q <= '0;
      act_hex_q  <= '0;
      act_pts_q  <= '0;
      act_les_q  <= '0;
      busy_q     <= 1'b0;
      an_q       <= AN_OFF;
      d_q        <= '0;
      le_q       <= 1'b0;
      pt_q       <= 1'b0;
    end else begin
      pend_hex_q <= pend_hex_d;
      pend_pts_q <= pend_pts_d;
      pend_les_q <= pend_les_d;
      act_hex_q  <= act_hex_d;
      act_pts_q  <= act_pts_d;
      act_les_q  <= act_les_d;
      busy_q     <= busy_d;
      an_q       <= an_d;
      d_q        <= d_d;
      le_q       <= le_d;
      pt_q       <= pt_d;
    end
  end

  assign bus.AN    = an_q;
  assign bus.D     = d_q;
  assign bus.LE    = le_q;
  assign bus.POINT = pt_q;
  assign bus.digit = digit_s;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV=8, BLANK_CYC=2.
module tb_disp_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  logic [15:0] m_hex = 16'h0, m_phex = 16'h0;
  logic [3:0]  m_pts = 4'h0, m_ppts = 4'h0;
  logic [3:0]  m_les = 4'h0, m_ples = 4'h0;
  logic        m_busy = 1'b0;

  disp_scan_ctrl_if bif ();

  disp_scan_ctrl #(
    .CNT_W     (16),
    .DIV       (16'd8),
    .BLANK_CYC (16'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d got=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    logic        ld, rs, lz, sup;
    logic [15:0] ih;
    logic [3:0]  ip, il, e_an, e_d;
    logic        e_le, e_pt;
    int          cp, dp;
    ld = bif.load; rs = rst; lz = bif.lzs;
    ih = bif.hexs; ip = bif.points; il = bif.les;
    @(posedge clk);
    #1;
    if (rs) begin
      n = 0;
      m_hex = 16'h0; m_pts = 4'h0; m_les = 4'h0;
      m_phex = 16'h0; m_ppts = 4'h0; m_ples = 4'h0; m_busy = 1'b0;
      chk("rst_an", {12'h0, bif.AN}, 16'hF);
      chk("rst_d", {12'h0, bif.D}, 16'h0);
      chk("rst_le", {15'h0, bif.LE}, 16'h0);
      chk("rst_pt", {15'h0, bif.POINT}, 16'h0);
      chk("rst_digit", {14'h0, bif.digit}, 16'h0);
      chk("rst_busy", {15'h0, bif.busy}, 16'h0);
    end else begin
      n++;
      cp = (n - 1) % 8;
      dp = ((n - 1) / 8) % 4;
      e_d = m_hex[dp*4 +: 4];
      sup = lz && (dp > 0) && ((m_hex >> (4 * dp)) == 16'h0);
      if (cp < 2) begin
        e_an = 4'b1111; e_le = 1'b0; e_pt = 1'b0;
      end else begin
        case (dp)
          0: e_an = 4'b1110;
          1: e_an = 4'b1101;
          2: e_an = 4'b1011;
          default: e_an = 4'b0111;
        endcase
        e_le = m_les[dp] && !sup;
        e_pt = m_pts[dp];
      end
      if ((n % 32) == 0 && m_busy) begin
        m_hex = m_phex; m_pts = m_ppts; m_les = m_ples; m_busy = 1'b0;
      end
      if (ld) begin
        m_phex = ih; m_ppts = ip; m_ples = il; m_busy = 1'b1;
      end
      chk("an", {12'h0, bif.AN}, {12'h0, e_an});
      chk("d", {12'h0, bif.D}, {12'h0, e_d});
      chk("le", {15'h0, bif.LE}, {15'h0, e_le});
      chk("pt", {15'h0, bif.POINT}, {15'h0, e_pt});
      chk("digit", {14'h0, bif.digit}, 16'((n / 8) % 4));
      chk("busy", {15'h0, bif.busy}, {15'h0, m_busy});
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    bif.hexs = h; bif.points = p; bif.les = l; bif.load = 1'b1;
    tick();
    bif.load = 1'b0;
  endtask

  initial begin
    bif.hexs = 16'h0; bif.points = 4'h0; bif.les = 4'h0;
    bif.lzs = 1'b0; bif.load = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to(2);
    chk("h_blank_an", {12'h0, bif.AN}, 16'hF);
    run_to(3);
    chk("h_drive0_an", {12'h0, bif.AN}, 16'hE);
    chk("h_drive0_le", {15'h0, bif.LE}, 16'h0);
    run_to(8);
    chk("h_digit1", {14'h0, bif.digit}, 16'h1);
    run_to(32);
    chk("h_digit_wrap", {14'h0, bif.digit}, 16'h0);

    do_load(16'h1234, 4'b0100, 4'hF);
    chk("h_busy_set", {15'h0, bif.busy}, 16'h1);
    run_to(63);
    chk("h_busy_hold", {15'h0, bif.busy}, 16'h1);
    run_to(64);
    chk("h_busy_clr", {15'h0, bif.busy}, 16'h0);
    run_to(67);
    chk("h_1234_d0", {12'h0, bif.D}, 16'h4);
    chk("h_1234_an0", {12'h0, bif.AN}, 16'hE);
    chk("h_1234_le0", {15'h0, bif.LE}, 16'h1);
    run_to(83);
    chk("h_1234_d2", {12'h0, bif.D}, 16'h2);
    chk("h_1234_an2", {12'h0, bif.AN}, 16'hB);
    chk("h_1234_pt2", {15'h0, bif.POINT}, 16'h1);
    run_to(96);

    bif.lzs = 1'b1;
    do_load(16'h0050, 4'h0, 4'hF);
    run_to(131);
    chk("h_lz50_d0_le", {15'h0, bif.LE}, 16'h1);
    run_to(139);
    chk("h_lz50_d1", {12'h0, bif.D}, 16'h5);
    chk("h_lz50_d1_le", {15'h0, bif.LE}, 16'h1);
    run_to(155);
    chk("h_lz50_d3_an", {12'h0, bif.AN}, 16'h7);
    chk("h_lz50_d3_le", {15'h0, bif.LE}, 16'h0);
    run_to(160);

    do_load(16'h0000, 4'h0, 4'hF);
    run_to(195);
    chk("h_lz0_d0_le", {15'h0, bif.LE}, 16'h1);
    run_to(203);
    chk("h_lz0_d1_le", {15'h0, bif.LE}, 16'h0);
    run_to(224);

    do_load(16'h0000, 4'h0, 4'b1110);
    run_to(259);
    chk("h_les_d0_le", {15'h0, bif.LE}, 16'h0);
    run_to(288);

    bif.lzs = 1'b0;
    do_load(16'hAAAA, 4'h0, 4'hF);
    run_to(295);
    do_load(16'hBBBB, 4'h0, 4'hF);
    chk("h_busy_reload", {15'h0, bif.busy}, 16'h1);
    run_to(323);
    chk("h_last_wins", {12'h0, bif.D}, 16'hB);
    run_to(340);
    do_load(16'hDDDD, 4'h0, 4'hF);
    run_to(351);
    do_load(16'hEEEE, 4'h0, 4'hF);
    chk("h_edge_busy", {15'h0, bif.busy}, 16'h1);
    run_to(355);
    chk("h_edge_old", {12'h0, bif.D}, 16'hD);
    run_to(387);
    chk("h_edge_new", {12'h0, bif.D}, 16'hE);
    chk("h_edge_busy_clr", {15'h0, bif.busy}, 16'h0);

    run_to(435);
    chk("h_pre_rst_digit", {14'h0, bif.digit}, 16'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to(35);
    chk("h_post_rst_an", {12'h0, bif.AN}, 16'hE);
    chk("h_post_rst_d", {12'h0, bif.D}, 16'h0);
    chk("h_post_rst_le", {15'h0, bif.LE}, 16'h0);
    run_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
